// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_slave_regfile
//  Brief    : AXI-Lite responder holding REG_NUM word registers. Register 0
//             is a read-only ID; register 1 is exported as a live control
//             output. Single-beat accesses only; malformed or out-of-range
//             accesses answer SLVERR and leave the bank untouched.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 'hA5A5_0001
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // write address channel
  input  logic [ADDR_WIDTH-1:0] AW_ADDR,
  input  logic [7:0]            AW_LEN,
  input  logic [2:0]            AW_SIZE,
  input  logic [1:0]            AW_BURST,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  // write data channel
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic                  W_LAST,
  input  logic                  W_VALID,
  output logic                  W_READY,
  // write response channel
  output logic [1:0]            B_RESP,
  output logic                  B_VALID,
  input  logic                  B_READY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  input  logic [7:0]            AR_LEN,
  input  logic [2:0]            AR_SIZE,
  input  logic [1:0]            AR_BURST,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  // read data channel
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_LAST,
  output logic                  R_VALID,
  input  logic                  R_READY,
  // control output
  output logic [DATA_WIDTH-1:0] REG1_OUT
);

  localparam int         IDX_W       = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  localparam logic [0:0] WS_ACCEPT = 1'b0;
  localparam logic [0:0] WS_RESP   = 1'b1;
  localparam logic [0:0] RS_ACCEPT = 1'b0;
  localparam logic [0:0] RS_DATA   = 1'b1;

  // ---------------------------------------------------------------- write side
  logic [0:0]            r_wstate;
  logic                  r_aw_ready;
  logic                  r_w_ready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len;
  logic [2:0]            r_aw_size;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_b_valid;
  logic [1:0]            r_b_resp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic                  w_wr_fire;
  logic                  w_wr_commit;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic [7:0]            w_aw_len;
  logic [2:0]            w_aw_size;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_aw_off;
  logic                  w_aw_err;
  logic [IDX_W-1:0]      w_aw_idx;
  logic                  w_wr_err;

  // ----------------------------------------------------------------- read side
  logic [0:0]            r_rstate;
  logic                  r_ar_ready;
  logic                  r_r_valid;
  logic                  r_r_last;
  logic [1:0]            r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data;

  logic                  w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_ar_off;
  logic                  w_ar_err;
  logic [IDX_W-1:0]      w_ar_idx;

  // Register bank as seen by readers; entry 0 is the constant ID
  logic [DATA_WIDTH-1:0] w_reg_view [REG_NUM];

  // Burst type and W_LAST carry no information for single-beat accesses
  logic                  w_unused_ok;
  assign w_unused_ok = ^{AW_BURST, AR_BURST, W_LAST};

  // Handshakes; a channel's own ready is only ever high in its accept state
  assign w_aw_hs = AW_VALID & r_aw_ready;
  assign w_w_hs  = W_VALID  & r_w_ready;
  assign w_ar_hs = AR_VALID & r_ar_ready;

  // A channel counts as present either from an earlier latch or this cycle
  assign w_aw_have = r_aw_done | w_aw_hs;
  assign w_w_have  = r_w_done  | w_w_hs;
  assign w_aw_addr = w_aw_hs ? AW_ADDR : r_aw_addr;
  assign w_aw_len  = w_aw_hs ? AW_LEN  : r_aw_len;
  assign w_aw_size = w_aw_hs ? AW_SIZE : r_aw_size;
  assign w_wdata   = w_w_hs  ? W_DATA  : r_w_data;

  // Write decode: offset relative to the bank base; a wrap below the base
  // produces a huge index and is rejected by the range check
  assign w_aw_off  = w_aw_addr - BASE_ADDR;
  assign w_aw_err  = (w_aw_addr[1:0] != 2'b00)
                   | ((w_aw_off >> 2) >= ADDR_WIDTH'(REG_NUM))
                   | (w_aw_len != 8'd0)
                   | (w_aw_size != SIZE_WORD);
  assign w_aw_idx  = w_aw_off[IDX_W+1:2];
  assign w_wr_err  = w_aw_err | (w_aw_idx == '0);

  assign w_wr_fire   = (r_wstate == WS_ACCEPT) & w_aw_have & w_w_have;
  assign w_wr_commit = w_wr_fire & ~w_wr_err;

  // Read decode, taken straight from the AR inputs in the handshake cycle
  assign w_ar_off = AR_ADDR - BASE_ADDR;
  assign w_ar_err = (AR_ADDR[1:0] != 2'b00)
                  | ((w_ar_off >> 2) >= ADDR_WIDTH'(REG_NUM))
                  | (AR_LEN != 8'd0)
                  | (AR_SIZE != SIZE_WORD);
  assign w_ar_idx = w_ar_off[IDX_W+1:2];

  assign w_reg_view[0] = ID_VALUE;

  for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_regs
    logic [DATA_WIDTH-1:0] r_q;

    // Writable register: loads on the commit edge of an OKAY write
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        r_q <= '0;
      end else if (w_wr_commit && (w_aw_idx == IDX_W'(gi))) begin
        r_q <= w_wdata;
      end
    end

    assign w_reg_view[gi] = r_q;
  end

  // Write FSM: collect AW and W independently, then answer on B
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate   <= WS_ACCEPT;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_w_data   <= '0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        WS_ACCEPT: begin
          if (w_aw_hs) begin
            r_aw_addr <= AW_ADDR;
            r_aw_len  <= AW_LEN;
            r_aw_size <= AW_SIZE;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_data <= W_DATA;
            r_w_done <= 1'b1;
          end
          if (w_wr_fire) begin
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b1;
            r_b_resp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_wstate   <= WS_RESP;
          end else begin
            // also raises both readies on the first edge after reset
            r_aw_ready <= ~w_aw_have;
            r_w_ready  <= ~w_w_have;
          end
        end
        WS_RESP: begin
          if (B_READY) begin
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b1;
            r_wstate   <= WS_ACCEPT;
          end
        end
        default: r_wstate <= WS_ACCEPT;
      endcase
    end
  end

  // Read FSM: sample the bank in the AR handshake cycle, hold until taken
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate   <= RS_ACCEPT;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_r_last   <= 1'b0;
      r_r_resp   <= RESP_OKAY;
      r_r_data   <= '0;
    end else begin
      case (r_rstate)
        RS_ACCEPT: begin
          if (w_ar_hs) begin
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b1;
            r_r_last   <= 1'b1;
            r_r_resp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_r_data   <= w_ar_err ? '0 : w_reg_view[w_ar_idx];
            r_rstate   <= RS_DATA;
          end else begin
            r_ar_ready <= 1'b1;
          end
        end
        RS_DATA: begin
          if (R_READY) begin
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_ar_ready <= 1'b1;
            r_rstate   <= RS_ACCEPT;
          end
        end
        default: r_rstate <= RS_ACCEPT;
      endcase
    end
  end

  assign AW_READY = r_aw_ready;
  assign W_READY  = r_w_ready;
  assign B_VALID  = r_b_valid;
  assign B_RESP   = r_b_resp;
  assign AR_READY = r_ar_ready;
  assign R_VALID  = r_r_valid;
  assign R_LAST   = r_r_last;
  assign R_RESP   = r_r_resp;
  assign R_DATA   = r_r_data;
  assign REG1_OUT = w_reg_view[1];

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_slave_regfile
//  Brief    : Directed bench for axi_lite_slave_regfile. Stimulus tasks push
//             the expected B/R responses into queues; a monitor pops them on
//             each B/R handshake and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regfile;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] AW_ADDR;
  logic [7:0]  AW_LEN;
  logic [2:0]  AW_SIZE;
  logic [1:0]  AW_BURST;
  logic        AW_VALID;
  logic        AW_READY;
  logic [31:0] W_DATA;
  logic        W_LAST;
  logic        W_VALID;
  logic        W_READY;
  logic [1:0]  B_RESP;
  logic        B_VALID;
  logic        B_READY;
  logic [31:0] AR_ADDR;
  logic [7:0]  AR_LEN;
  logic [2:0]  AR_SIZE;
  logic [1:0]  AR_BURST;
  logic        AR_VALID;
  logic        AR_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_LAST;
  logic        R_VALID;
  logic        R_READY;
  logic [31:0] REG1_OUT;

  axi_lite_slave_regfile dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN), .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_LAST(W_LAST), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN), .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST), .R_VALID(R_VALID),
    .R_READY(R_READY), .REG1_OUT(REG1_OUT)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0] wb_q [$];
  rd_exp_t    rd_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: each B or R handshake consumes one expected entry
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (B_VALID && B_READY) begin
        if (wb_q.size() == 0) fail("b_unexpected");
        else chk("b_resp", {30'd0, B_RESP}, {30'd0, wb_q.pop_front()});
      end
      if (R_VALID && R_READY) begin
        if (rd_q.size() == 0) fail("r_unexpected");
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("r_data", R_DATA, e.data);
          chk("r_resp", {30'd0, R_RESP}, {30'd0, e.resp});
          chk("r_last", {31'd0, R_LAST}, 32'd1);
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    AW_ADDR = a; AW_LEN = len; AW_SIZE = 3'b010; AW_BURST = 2'b01; AW_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (AW_READY) ok = 1'b1;
      cyc();
    end
    AW_VALID = 1'b0;
    if (!ok) fail("aw_timeout");
  endtask

  task automatic send_w(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    W_DATA = d; W_LAST = 1'b1; W_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (W_READY) ok = 1'b1;
      cyc();
    end
    W_VALID = 1'b0;
    if (!ok) fail("w_timeout");
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] size);
    bit ok;
    ok = 1'b0;
    AR_ADDR = a; AR_LEN = 8'd0; AR_SIZE = size; AR_BURST = 2'b01; AR_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (AR_READY) ok = 1'b1;
      cyc();
    end
    AR_VALID = 1'b0;
    if (!ok) fail("ar_timeout");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] len,
                    input logic [1:0] exp_resp);
    wb_q.push_back(exp_resp);
    fork
      send_aw(a, len);
      send_w(d);
    join
    chk("b_latency", {31'd0, B_VALID}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] size,
                    input logic [31:0] exp_d, input logic [1:0] exp_r);
    rd_exp_t e;
    e.data = exp_d;
    e.resp = exp_r;
    rd_q.push_back(e);
    send_ar(a, size);
    chk("r_latency", {31'd0, R_VALID}, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge ACLK);
      if (wb_q.size() == 0 && rd_q.size() == 0 && !B_VALID && !R_VALID) idle = 1'b1;
    end
    if (!idle) fail("idle_timeout");
    cyc();
  endtask

  initial begin
    ARESETn = 1'b0;
    AW_ADDR = '0; AW_LEN = '0; AW_SIZE = '0; AW_BURST = '0; AW_VALID = 1'b0;
    W_DATA = '0; W_LAST = 1'b0; W_VALID = 1'b0; B_READY = 1'b1;
    AR_ADDR = '0; AR_LEN = '0; AR_SIZE = '0; AR_BURST = '0; AR_VALID = 1'b0;
    R_READY = 1'b1;

    // Reset values
    repeat (3) cyc();
    chk("rst_aw_ready", {31'd0, AW_READY}, 32'd0);
    chk("rst_w_ready",  {31'd0, W_READY},  32'd0);
    chk("rst_ar_ready", {31'd0, AR_READY}, 32'd0);
    chk("rst_b_valid",  {31'd0, B_VALID},  32'd0);
    chk("rst_r_valid",  {31'd0, R_VALID},  32'd0);
    chk("rst_r_data",   R_DATA,   32'd0);
    chk("rst_reg1",     REG1_OUT, 32'd0);
    ARESETn = 1'b1;
    cyc();
    chk("rel_aw_ready", {31'd0, AW_READY}, 32'd1);
    chk("rel_ar_ready", {31'd0, AR_READY}, 32'd1);

    // AW and W together
    wr(32'h04, 32'hDEADBEEF, 8'd0, 2'b00);
    wait_idle();
    chk("reg1_out", REG1_OUT, 32'hDEADBEEF);
    rd(32'h04, 3'b010, 32'hDEADBEEF, 2'b00);
    wait_idle();

    // W three cycles ahead of AW
    wb_q.push_back(2'b00);
    fork
      begin
        send_w(32'h12345678);
        chk("w_ready_drop", {31'd0, W_READY}, 32'd0);
      end
      begin
        repeat (3) cyc();
        send_aw(32'h08, 8'd0);
        chk("b_after_aw", {31'd0, B_VALID}, 32'd1);
      end
    join
    wait_idle();
    rd(32'h08, 3'b010, 32'h12345678, 2'b00);
    wait_idle();

    // ID register: readable, not writable
    rd(32'h00, 3'b010, 32'hA5A50001, 2'b00);
    wr(32'h00, 32'h0, 8'd0, 2'b10);
    wait_idle();
    rd(32'h00, 3'b010, 32'hA5A50001, 2'b00);
    wait_idle();

    // Error decodes
    rd(32'h40, 3'b010, 32'h0, 2'b10);
    wait_idle();
    rd(32'h05, 3'b010, 32'h0, 2'b10);
    wait_idle();
    rd(32'h04, 3'b011, 32'h0, 2'b10);
    wait_idle();
    wr(32'h0C, 32'hFFFF_FFFF, 8'd1, 2'b10);
    wait_idle();
    rd(32'h0C, 3'b010, 32'h0, 2'b00);
    wait_idle();
    wr(32'h3C, 32'hCAFE_F00D, 8'd0, 2'b00);
    wait_idle();
    rd(32'h3C, 3'b010, 32'hCAFE_F00D, 2'b00);
    wait_idle();

    // Same-edge read and write of register 1: read sees the old value
    wb_q.push_back(2'b00);
    begin
      rd_exp_t e;
      e.data = 32'hDEADBEEF;
      e.resp = 2'b00;
      rd_q.push_back(e);
    end
    fork
      send_aw(32'h04, 8'd0);
      send_w(32'h0BADF00D);
      send_ar(32'h04, 3'b010);
    join
    wait_idle();
    chk("reg1_new", REG1_OUT, 32'h0BADF00D);
    rd(32'h04, 3'b010, 32'h0BADF00D, 2'b00);
    wait_idle();

    // B back-pressure with a concurrent read
    B_READY = 1'b0;
    wr(32'h10, 32'h0000_0055, 8'd0, 2'b00);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge ACLK);
          chk("b_hold_valid", {31'd0, B_VALID}, 32'd1);
          chk("b_hold_resp",  {30'd0, B_RESP},  32'd0);
          chk("b_hold_awrdy", {31'd0, AW_READY}, 32'd0);
          chk("b_hold_wrdy",  {31'd0, W_READY},  32'd0);
        end
      end
      rd(32'h08, 3'b010, 32'h12345678, 2'b00);
    join
    B_READY = 1'b1;
    wait_idle();

    // R back-pressure with a concurrent write
    R_READY = 1'b0;
    rd(32'h10, 3'b010, 32'h0000_0055, 2'b00);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge ACLK);
          chk("r_hold_valid", {31'd0, R_VALID}, 32'd1);
          chk("r_hold_data",  R_DATA, 32'h0000_0055);
          chk("r_hold_last",  {31'd0, R_LAST}, 32'd1);
          chk("r_hold_arrdy", {31'd0, AR_READY}, 32'd0);
        end
      end
      wr(32'h14, 32'h0000_0066, 8'd0, 2'b00);
    join
    R_READY = 1'b1;
    wait_idle();
    rd(32'h14, 3'b010, 32'h0000_0066, 2'b00);
    wait_idle();

    // Reset while a B response is pending
    B_READY = 1'b0;
    wr(32'h18, 32'h0000_0077, 8'd0, 2'b00);
    ARESETn = 1'b0;
    #1;
    chk("arst_b_valid", {31'd0, B_VALID}, 32'd0);
    chk("arst_reg1",    REG1_OUT, 32'd0);
    chk("arst_awrdy",   {31'd0, AW_READY}, 32'd0);
    wb_q.delete();
    B_READY = 1'b1;
    cyc();
    ARESETn = 1'b1;
    cyc();
    rd(32'h04, 3'b010, 32'h0, 2'b00);
    wait_idle();
    rd(32'h18, 3'b010, 32'h0, 2'b00);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
